// File: rtl/rect_plotter_pkg.sv
// Shared constants, FSM encoding and palette for the framebuffer storing-mode path.
package rect_plotter_pkg;
  localparam int H_RES    = 160;
  localparam int V_RES    = 120;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAW  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [COLOUR_W-1:0] COL_BACKGROUND = 3'b000;
  localparam logic [COLOUR_W-1:0] COL_DON        = 3'b100;
  localparam logic [COLOUR_W-1:0] COL_KA         = 3'b001;

  // Walk counters are one bit wider than the screen so a rectangle that runs off the edge never wraps back on.
  function automatic logic on_screen(input logic [X_W:0] x, input logic [Y_W:0] y);
    return (x < (X_W+1)'(H_RES)) && (y < (Y_W+1)'(V_RES));
  endfunction
endpackage

// File: rtl/rect_plotter_addr_calc.sv
// Linear framebuffer address y*H_RES + x, built from shifts (160 = 128 + 32).
module fb_addr_calc
  import rect_plotter_pkg::*;
(
  input  logic [X_W-1:0]    i_x,
  input  logic [Y_W-1:0]    i_y,
  output logic [ADDR_W-1:0] o_addr
);
  assign o_addr = (ADDR_W'(i_y) << 7) + (ADDR_W'(i_y) << 5) + ADDR_W'(i_x);
endmodule

// File: rtl/rect_plotter.sv
// Storing-mode writer: walks a rectangle (or the whole screen) row-major and drives the framebuffer write port.
// state | meaning
// IDLE  | waiting for start; VGA_display released
// LOAD  | request latched, muxes claimed; skip to FLUSH on empty rectangle
// DRAW  | one pixel per unstalled cycle, off-screen pixels clipped
// FLUSH | last write lands while the muxes are still held
// DONE  | one-cycle done pulse, muxes released
module rect_plotter
  import rect_plotter_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_clear,
  input  logic [X_W-1:0]      i_x0,
  input  logic [Y_W-1:0]      i_y0,
  input  logic [X_W-1:0]      i_width,
  input  logic [Y_W-1:0]      i_height,
  input  logic [COLOUR_W-1:0] i_colour,
  input  logic                i_stall,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_vga_display,
  output logic [X_W-1:0]      o_sending_x,
  output logic [Y_W-1:0]      o_sending_y,
  output logic [ADDR_W-1:0]   o_storing_mode_address,
  output logic [COLOUR_W-1:0] o_plot_colour,
  output logic                o_plot
);
  state_t              r_state;
  logic [X_W-1:0]      r_x0;
  logic [Y_W-1:0]      r_y0;
  logic [X_W-1:0]      r_w;
  logic [Y_W-1:0]      r_h;
  logic [COLOUR_W-1:0] r_colour;
  logic [X_W:0]        r_x;
  logic [Y_W:0]        r_y;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_busy;
  logic                r_done;
  logic                r_vga;
  logic                r_plot;

  logic [X_W:0]        w_x_end;
  logic [Y_W:0]        w_y_end;
  logic [X_W:0]        w_nx;
  logic [Y_W:0]        w_ny;
  logic                w_last;
  logic [ADDR_W-1:0]   w_addr;

  assign w_x_end = {1'b0, r_x0} + {1'b0, r_w} - (X_W+1)'(1);
  assign w_y_end = {1'b0, r_y0} + {1'b0, r_h} - (Y_W+1)'(1);
  assign w_last  = (r_x == w_x_end) && (r_y == w_y_end);

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (r_state == ST_LOAD) begin
      w_nx = {1'b0, r_x0};
      w_ny = {1'b0, r_y0};
    end else if (r_x == w_x_end) begin
      w_nx = {1'b0, r_x0};
      w_ny = r_y + (Y_W+1)'(1);
    end else begin
      w_nx = r_x + (X_W+1)'(1);
    end
  end

  // Address is computed from the next pixel so it is registered in step with sending_X/Y.
  fb_addr_calc u_addr (
    .i_x    (w_nx[X_W-1:0]),
    .i_y    (w_ny[Y_W-1:0]),
    .o_addr (w_addr)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ST_IDLE;
      r_x0     <= '0;
      r_y0     <= '0;
      r_w      <= '0;
      r_h      <= '0;
      r_colour <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_addr   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_vga    <= 1'b0;
      r_plot   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state  <= ST_LOAD;
            r_busy   <= 1'b1;
            r_vga    <= 1'b1;
            r_colour <= i_colour;
            if (i_clear) begin
              r_x0 <= '0;
              r_y0 <= '0;
              r_w  <= X_W'(H_RES);
              r_h  <= Y_W'(V_RES);
            end else begin
              r_x0 <= i_x0;
              r_y0 <= i_y0;
              r_w  <= i_width;
              r_h  <= i_height;
            end
          end
        end
        ST_LOAD: begin
          if ((r_w == '0) || (r_h == '0)) begin
            r_state <= ST_FLUSH;
          end else begin
            r_state <= ST_DRAW;
            r_x     <= w_nx;
            r_y     <= w_ny;
            r_addr  <= w_addr;
            r_plot  <= on_screen(w_nx, w_ny);
          end
        end
        ST_DRAW: begin
          if (i_stall) begin
            r_plot <= 1'b0;
          end else if (w_last) begin
            r_state <= ST_FLUSH;
            r_plot  <= 1'b0;
          end else begin
            r_x    <= w_nx;
            r_y    <= w_ny;
            r_addr <= w_addr;
            r_plot <= on_screen(w_nx, w_ny);
          end
        end
        ST_FLUSH: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_vga   <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy                 = r_busy;
  assign o_done                 = r_done;
  assign o_vga_display          = r_vga;
  assign o_sending_x            = r_x[X_W-1:0];
  assign o_sending_y            = r_y[Y_W-1:0];
  assign o_storing_mode_address = r_addr;
  assign o_plot_colour          = r_colour;
  assign o_plot                 = r_plot;
endmodule
